// File: rtl/receptor_pkg.sv
// ============================================================================
// receptor_pkg : shared state encodings and sizing helpers for receptor_serie
// Rev 1.0
// ============================================================================
`default_nettype none

package receptor_pkg;

  localparam int WIDTH_DEF = 25;

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] START  = 3'd1;
  localparam logic [2:0] DATA   = 3'd2;
  localparam logic [2:0] PARITY = 3'd3;
  localparam logic [2:0] STOP   = 3'd4;
  localparam logic [2:0] ESPERA = 3'd5;

  // Bit-counter width; never below one bit so degenerate widths still elaborate.
  function automatic int nb_ancho(input int w);
    return (w > 1) ? $clog2(w) : 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/sincronizador_rx.sv
// ============================================================================
// sincronizador_rx : two-flop synchroniser for the serial line, resets to idle (1)
// Rev 1.0
// ============================================================================
`default_nettype none

module sincronizador_rx (
  input  logic clk,
  input  logic rst_n,
  input  logic rx_i,
  output logic rx_s_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
    end else begin
      meta_q <= rx_i;
      sync_q <= meta_q;
    end
  end

  assign rx_s_o = sync_q;

endmodule

`default_nettype wire

// File: rtl/receptor_serie.sv
// ============================================================================
// receptor_serie : serial-to-word deserialiser feeding the 25-bit word register
// Optional even parity bit enabled with macro PARIDAD_EN.  Rev 1.0
// ============================================================================
`default_nettype none

module receptor_serie
  import receptor_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int DIV   = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             rx,
  output logic [WIDTH-1:0] dato,
  output logic             leer,
  output logic             error_trama,
  output logic             ocupado
);

  localparam int CW  = $clog2(DIV);
  localparam int NBW = nb_ancho(WIDTH);

  localparam logic [CW-1:0]  C_FIN  = CW'(DIV - 1);
  localparam logic [CW-1:0]  C_MED  = CW'(DIV / 2 - 1);
  localparam logic [NBW-1:0] NB_FIN = NBW'(WIDTH - 1);

  logic             rx_s;
  logic [2:0]       state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [NBW-1:0]   nb_q, nb_d;
  logic [WIDTH-1:0] sr_q, sr_d;
  logic [WIDTH-1:0] dato_q, dato_d;
  logic             leer_q, leer_d;
  logic             err_q, err_d;
`ifdef PARIDAD_EN
  logic             perr_q, perr_d;
`endif

  sincronizador_rx u_sync (
    .clk    (clk),
    .rst_n  (rst_n),
    .rx_i   (rx),
    .rx_s_o (rx_s)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = (cnt_q == C_FIN) ? '0 : cnt_q + 1'b1;
    nb_d    = nb_q;
    sr_d    = sr_q;
    dato_d  = dato_q;
    leer_d  = 1'b0;
    err_d   = 1'b0;
`ifdef PARIDAD_EN
    perr_d  = perr_q;
`endif
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (!rx_s) state_d = START;
      end
      START: begin
        if (cnt_q == C_MED) begin
          cnt_d = '0;
          if (!rx_s) begin
            state_d = DATA;
            nb_d    = '0;
`ifdef PARIDAD_EN
            perr_d  = 1'b0;
`endif
          end else begin
            state_d = IDLE;
          end
        end
      end
      DATA: begin
        if (cnt_q == C_FIN) begin
          sr_d = {rx_s, sr_q[WIDTH-1:1]};
          if (nb_q == NB_FIN) begin
`ifdef PARIDAD_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end else begin
            nb_d = nb_q + 1'b1;
          end
        end
      end
`ifdef PARIDAD_EN
      PARITY: begin
        if (cnt_q == C_FIN) begin
          perr_d  = (^sr_q) ^ rx_s;
          state_d = STOP;
        end
      end
`endif
      STOP: begin
        if (cnt_q == C_FIN) begin
          state_d = rx_s ? IDLE : ESPERA;
`ifdef PARIDAD_EN
          if (perr_q || !rx_s) begin
`else
          if (!rx_s) begin
`endif
            err_d = 1'b1;
          end else begin
            leer_d = 1'b1;
            dato_d = sr_q;
          end
        end
      end
      // A stuck-low line stays here so it can never look like a new start bit.
      ESPERA: begin
        cnt_d = '0;
        if (rx_s) state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      nb_q    <= '0;
      sr_q    <= '0;
      dato_q  <= '0;
      leer_q  <= 1'b0;
      err_q   <= 1'b0;
`ifdef PARIDAD_EN
      perr_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      nb_q    <= nb_d;
      sr_q    <= sr_d;
      dato_q  <= dato_d;
      leer_q  <= leer_d;
      err_q   <= err_d;
`ifdef PARIDAD_EN
      perr_q  <= perr_d;
`endif
    end
  end

  assign dato        = dato_q;
  assign leer        = leer_q;
  assign error_trama = err_q;
  assign ocupado     = (state_q != IDLE);

endmodule

`default_nettype wire

// File: tb/tb_receptor_serie.sv
// ============================================================================
// tb_receptor_serie : scoreboard bench for receptor_serie (DIV=4, WIDTH=25)
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_receptor_serie;

  localparam int W   = 25;
  localparam int DIV = 4;
`ifdef PARIDAD_EN
  localparam int FRAME_BITS = W + 3;
`else
  localparam int FRAME_BITS = W + 2;
`endif

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         rx = 1'b1;
  logic [W-1:0] dato;
  logic         leer;
  logic         error_trama;
  logic         ocupado;

  typedef struct {
    bit           is_err;
    logic [W-1:0] dato;
  } exp_t;

  exp_t         sb[$];
  int           vectors = 0;
  int           miscompares = 0;
  int           cyc = 0;
  int           t_last = 0;
  int           t_prev = 0;
  bit           prev_strobe = 1'b0;
  logic [W-1:0] last;

  receptor_serie #(.WIDTH(W), .DIV(DIV)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .rx          (rx),
    .dato        (dato),
    .leer        (leer),
    .error_trama (error_trama),
    .ocupado     (ocupado)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    vectors++;
    if (act !== expv) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h", name, act, expv);
    end
  endtask

  task automatic idle(input int n);
    rx = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  // Drives one frame bit by bit; nbits truncates the frame for abort tests.
  task automatic send_frame(input logic [W-1:0] w, input logic stop,
                            input logic pflip, input int nbits);
    logic [W+2:0] f;
    f = '0;
    f[W:1] = w;
`ifdef PARIDAD_EN
    f[W+1] = (^w) ^ pflip;
    f[W+2] = stop;
`else
    f[W+1] = stop;
    f[W+2] = pflip;
`endif
    for (int i = 0; i < FRAME_BITS && i < nbits; i++) begin
      rx = f[i];
      repeat (DIV) @(negedge clk);
    end
  endtask

  task automatic expect_word(input logic [W-1:0] w);
    exp_t e;
    e.is_err = 1'b0;
    e.dato   = w;
    sb.push_back(e);
  endtask

  task automatic expect_error(input logic [W-1:0] held);
    exp_t e;
    e.is_err = 1'b1;
    e.dato   = held;
    sb.push_back(e);
  endtask

  // Monitor: pops one expectation per strobe cycle.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (leer || error_trama) begin
        if (sb.size() == 0) begin
          chk("unexpected_strobe", {30'd0, leer, error_trama}, 32'd0);
        end else begin
          e = sb.pop_front();
          chk("strobe_leer", {31'd0, leer}, {31'd0, !e.is_err});
          chk("strobe_error", {31'd0, error_trama}, {31'd0, e.is_err});
          chk("strobe_dato", {7'd0, dato}, {7'd0, e.dato});
          chk("strobe_one_cycle", {31'd0, prev_strobe}, 32'd0);
          if (leer) chk("ocupado_at_leer", {31'd0, ocupado}, 32'd0);
        end
        if (leer) begin
          t_prev = t_last;
          t_last = cyc;
        end
      end
      prev_strobe = leer | error_trama;
    end
  end

  initial begin
    rst_n = 1'b0;
    rx    = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset_dato", {7'd0, dato}, 32'd0);
    chk("reset_leer", {31'd0, leer}, 32'd0);
    chk("reset_error", {31'd0, error_trama}, 32'd0);
    chk("reset_ocupado", {31'd0, ocupado}, 32'd0);
    rst_n = 1'b1;
    idle(6);

    // Single clean frame
    expect_word(25'h1AAAAAA);
    send_frame(25'h1AAAAAA, 1'b1, 1'b0, 99);
    last = 25'h1AAAAAA;
    idle(12);

    // Back-to-back, no idle bits
    expect_word(25'h0123456);
    expect_word(25'h15AC871);
    send_frame(25'h0123456, 1'b1, 1'b0, 99);
    send_frame(25'h15AC871, 1'b1, 1'b0, 99);
    last = 25'h15AC871;
    idle(12);
    chk("b2b_spacing", t_last - t_prev, FRAME_BITS * DIV);
    chk("b2b_final_dato", {7'd0, dato}, {7'd0, last});

    // Stop bit low, then line held low
    expect_error(last);
    send_frame(25'h0FFFFFF, 1'b0, 1'b0, 99);
    rx = 1'b0;
    repeat (20) @(negedge clk);
    chk("stuck_low_ocupado", {31'd0, ocupado}, 32'd1);
    idle(8);
    chk("after_stuck_ocupado", {31'd0, ocupado}, 32'd0);
    chk("after_stuck_dato", {7'd0, dato}, {7'd0, last});

    // One-clock glitch
    rx = 1'b0;
    @(negedge clk);
    idle(20);
    chk("glitch_ocupado", {31'd0, ocupado}, 32'd0);
    chk("glitch_dato", {7'd0, dato}, {7'd0, last});

    // Reset in the middle of the data bits
    send_frame(25'h0ABCD12, 1'b1, 1'b0, 10);
    chk("midframe_ocupado", {31'd0, ocupado}, 32'd1);
    rx    = 1'b1;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    chk("midreset_dato", {7'd0, dato}, 32'd0);
    chk("midreset_leer", {31'd0, leer}, 32'd0);
    chk("midreset_error", {31'd0, error_trama}, 32'd0);
    chk("midreset_ocupado", {31'd0, ocupado}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    last  = '0;
    idle(8);
    expect_word(25'h0221133);
    send_frame(25'h0221133, 1'b1, 1'b0, 99);
    last = 25'h0221133;
    idle(12);

`ifdef PARIDAD_EN
    expect_word(25'h1524687);
    send_frame(25'h1524687, 1'b1, 1'b0, 99);
    last = 25'h1524687;
    idle(12);
    expect_error(last);
    send_frame(25'h1524687, 1'b1, 1'b1, 99);
    idle(12);
    chk("parity_err_ocupado", {31'd0, ocupado}, 32'd0);
`endif

    chk("scoreboard_drained", sb.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
